// File: rtl/servo_pkg.sv
// servo_pkg: shared state encoding, position type and defaults for the servo PWM driver.
package servo_pkg;

  // Driver state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } servo_state_e;

  // Servo position, 0..255.
  typedef logic [7:0] servo_pos_t;

  localparam servo_pos_t  CENTER_DEFAULT = 8'd128;
  localparam int unsigned SLEW_DEFAULT   = 32'd4;

  // Pulse width in clk cycles for a given position.
  function automatic int unsigned pulse_cycles(
    input servo_pos_t  pos,
    input int unsigned min_cyc,
    input int unsigned step_cyc
  );
    return min_cyc + (32'(pos) * step_cyc);
  endfunction

endpackage

// File: rtl/servo_slew_step.sv
// servo_slew_step: combinational rate limiter that moves a position toward
// its target by at most i_slew LSBs, snapping to the target when close.
module servo_slew_step
  import servo_pkg::*;
(
  input  servo_pos_t i_pos,
  input  servo_pos_t i_target,
  input  logic [7:0] i_slew,
  output servo_pos_t o_next_pos
);

  logic signed [8:0] diff_s;
  logic signed [8:0] slew_s;
  logic signed [8:0] next_s;

  // Signed 9-bit distance to target decides snap, step up or step down.
  always_comb begin
    diff_s = $signed({1'b0, i_target}) - $signed({1'b0, i_pos});
    slew_s = $signed({1'b0, i_slew});
    if (diff_s > slew_s) begin
      next_s = $signed({1'b0, i_pos}) + slew_s;
    end else if (diff_s < -slew_s) begin
      next_s = $signed({1'b0, i_pos}) - slew_s;
    end else begin
      next_s = $signed({1'b0, i_target});
    end
    // Target lies beyond the step, so next_s always stays within 0..255.
    o_next_pos = next_s[7:0];
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: hobby-servo PWM generator with a one-deep command buffer,
// per-frame slew limiting and glitch-free enable/disable at frame boundaries.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYC = 32'd500000,
  parameter int unsigned MIN_CYC   = 32'd25000,
  parameter int unsigned STEP_CYC  = 32'd98,
  parameter int unsigned SLEW      = SLEW_DEFAULT,
  parameter servo_pos_t  CENTER    = CENTER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Enable,
  input  logic       i_Cmd_Valid,
  input  logic [7:0] i_Cmd_Pos,
  output logic       o_Cmd_Ready,
  output logic       o_Pwm,
  output logic [7:0] o_Position,
  output logic       o_Frame_Start
);

  localparam int unsigned       CNT_W      = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_CYC - 32'd1);
  localparam logic [7:0]        SLEW_LSB   = 8'(SLEW);
  localparam logic [CNT_W-1:0]  RST_WIDTH  = CNT_W'(pulse_cycles(CENTER, MIN_CYC, STEP_CYC));

  // The longest pulse must end before the frame does.
  if (MIN_CYC + (32'd255 * STEP_CYC) >= FRAME_CYC) begin : g_chk_width
    $error("servo_pwm_driver: MIN_CYC + 255*STEP_CYC must be below FRAME_CYC");
  end
  // A zero-width pulse would make the HIGH state meaningless.
  if (MIN_CYC < 32'd1) begin : g_chk_min
    $error("servo_pwm_driver: MIN_CYC must be at least 1");
  end
  // Slew of zero would freeze the servo; above 255 does not fit the step path.
  if ((SLEW < 32'd1) || (SLEW > 32'd255)) begin : g_chk_slew
    $error("servo_pwm_driver: SLEW must be within 1..255");
  end

  servo_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pwm_q, pwm_d;
  logic             frame_start_q, frame_start_d;
  logic             pend_full_q, pend_full_d;
  servo_pos_t       pend_pos_q, pend_pos_d;
  servo_pos_t       target_q, target_d;
  servo_pos_t       position_q, position_d;

  logic             cmd_accept_s;
  logic             start_frame_s;
  servo_pos_t       target_sel_s;
  servo_pos_t       next_pos_s;

  // A frame start first promotes a pending command to target, then steps toward it.
  assign cmd_accept_s = i_Cmd_Valid & ~pend_full_q;
  assign target_sel_s = pend_full_q ? pend_pos_q : target_q;

  servo_slew_step u_slew (
    .i_pos      (position_q),
    .i_target   (target_sel_s),
    .i_slew     (SLEW_LSB),
    .o_next_pos (next_pos_s)
  );

  // Next-state logic: frame sequencing, command buffering and per-frame updates.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    width_d       = width_q;
    pwm_d         = 1'b0;
    frame_start_d = 1'b0;
    pend_full_d   = pend_full_q;
    pend_pos_d    = pend_pos_q;
    target_d      = target_q;
    position_d    = position_q;
    start_frame_s = 1'b0;

    if (cmd_accept_s) begin
      pend_full_d = 1'b1;
      pend_pos_d  = i_Cmd_Pos;
    end else begin
      pend_full_d = pend_full_q;
      pend_pos_d  = pend_pos_q;
    end

    case (state_q)
      IDLE: begin
        if (i_Enable) begin
          start_frame_s = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == (width_q - CNT_ONE)) begin
          state_d = LOW;
          pwm_d   = 1'b0;
        end else begin
          pwm_d   = 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == FRAME_LAST) begin
          if (i_Enable) begin
            start_frame_s = 1'b1;
          end else begin
            // Disabled: finish the frame quietly and park.
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    if (start_frame_s) begin
      state_d       = HIGH;
      cnt_d         = CNT_ZERO;
      pwm_d         = 1'b1;
      frame_start_d = 1'b1;
      target_d      = target_sel_s;
      position_d    = next_pos_s;
      width_d       = CNT_W'(pulse_cycles(next_pos_s, MIN_CYC, STEP_CYC));
      // A full buffer drains into target here; an empty one may accept the
      // command offered in this cycle, which then waits for the next frame.
      pend_full_d   = cmd_accept_s;
    end else begin
      target_d      = target_q;
      position_d    = position_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      width_q       <= RST_WIDTH;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      pend_full_q   <= 1'b0;
      pend_pos_q    <= CENTER;
      target_q      <= CENTER;
      position_q    <= CENTER;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      pend_full_q   <= pend_full_d;
      pend_pos_q    <= pend_pos_d;
      target_q      <= target_d;
      position_q    <= position_d;
    end
  end

  assign o_Pwm         = pwm_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Position    = position_q;
  assign o_Cmd_Ready   = ~pend_full_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: frame-level reference model compared every cycle,
// directed scenarios with hand-computed pulse/position values, then random traffic.
module tb_servo_pwm_driver;

  localparam int FRAME = 1000;
  localparam int MINC  = 100;
  localparam int STEPC = 2;
  localparam int SLEWP = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic       cv    = 1'b0;
  logic [7:0] cp    = 8'd0;
  logic       cmd_ready;
  logic       pwm;
  logic       frame_start;
  logic [7:0] position;

  servo_pwm_driver #(
    .FRAME_CYC (FRAME),
    .MIN_CYC   (MINC),
    .STEP_CYC  (STEPC),
    .SLEW      (SLEWP),
    .CENTER    (8'd128)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_Enable      (en),
    .i_Cmd_Valid   (cv),
    .i_Cmd_Pos     (cp),
    .o_Cmd_Ready   (cmd_ready),
    .o_Pwm         (pwm),
    .o_Position    (position),
    .o_Frame_Start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  logic       s_reset, s_en, s_cv;
  logic [7:0] s_cp;
  always @(posedge clk) begin
    s_reset <= reset;
    s_en    <= en;
    s_cv    <= cv;
    s_cp    <= cp;
  end

  // Reference model: frame time t since the frame began, in-frame flag, target/position.
  bit m_ok  = 1'b0;
  bit m_run = 1'b0;
  int m_t   = 0;
  int m_pos = 128;
  int m_tgt = 128;
  int m_pend[$];

  function automatic int step_toward(input int p, input int t);
    if (t - p > SLEWP) return p + SLEWP;
    if (p - t > SLEWP) return p - SLEWP;
    return t;
  endfunction

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // Observed history for directed checks.
  int cyc = 0;
  int run_len = 0;
  int fs_cnt = 0;
  int pulses[$];
  int fs_pos[$];
  int fs_cyc[$];

  // Model update and per-cycle comparison, plus pulse/frame monitor.
  initial begin
    bit acc;
    bit start;
    forever begin
      @(negedge clk);
      if (s_reset === 1'b1) begin
        m_run = 1'b0; m_t = 0; m_pos = 128; m_tgt = 128;
        m_pend.delete();
        m_ok = 1'b1;
      end else if (m_ok) begin
        acc   = (s_cv === 1'b1) && (m_pend.size() == 0);
        start = 1'b0;
        if (m_run) begin
          m_t++;
          if (m_t == FRAME) begin
            if (s_en === 1'b1) start = 1'b1;
            else begin m_run = 1'b0; m_t = 0; end
          end
        end else if (s_en === 1'b1) begin
          start = 1'b1;
        end
        if (start) begin
          if (m_pend.size() > 0) m_tgt = m_pend.pop_front();
          m_pos = step_toward(m_pos, m_tgt);
          m_t   = 0;
          m_run = 1'b1;
        end
        if (acc) m_pend.push_back(int'(s_cp));
      end
      if (m_ok) begin
        check("pwm", int'(pwm), (m_run && (m_t < MINC + m_pos * STEPC)) ? 1 : 0);
        check("frame_start", int'(frame_start), (m_run && m_t == 0) ? 1 : 0);
        check("cmd_ready", int'(cmd_ready), (m_pend.size() == 0) ? 1 : 0);
        check("position", int'(position), m_pos);
      end
      if (pwm === 1'b1) run_len++;
      else begin
        if (run_len > 0) pulses.push_back(run_len);
        run_len = 0;
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        fs_pos.push_back(int'(position));
        fs_cyc.push_back(cyc);
      end
      cyc++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pulses.delete();
    fs_pos.delete();
    fs_cyc.delete();
  endtask

  task automatic wait_fs(input int n, input string nm);
    int start_cnt;
    int b;
    start_cnt = fs_cnt;
    b = 0;
    while (((fs_cnt - start_cnt) < n) && (b < n * FRAME + 100)) begin
      tick();
      b++;
    end
    check(nm, ((fs_cnt - start_cnt) >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int exp_pos[4];
    int exp_pw[4];
    int b;
    bit rdy_seen;
    int fs_before;
    exp_pos = '{132, 136, 140, 140};
    exp_pw  = '{364, 372, 380, 380};

    check("model_step_up", step_toward(128, 140), 132);
    check("model_step_snap", step_toward(3, 0), 0);

    // Scenario 1: reset values, then steady centred frames.
    repeat (3) tick();
    check("rst_pwm", int'(pwm), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_pos", int'(position), 128);
    reset = 1'b0;
    en    = 1'b1;
    clear_mon();
    wait_fs(4, "s1_wait");
    for (int i = 0; i < 3; i++) begin
      check("s1_pulse", qget(pulses, i), 356);
      check("s1_period", qget(fs_cyc, i + 1) - qget(fs_cyc, i), 1000);
      check("s1_pos", qget(fs_pos, i), 128);
    end

    // Scenario 2: command 140 mid-frame, slewed 4 per frame.
    repeat (400) tick();
    cv = 1'b1; cp = 8'd140;
    tick();
    cv = 1'b0;
    check("s2_ready_after_accept", int'(cmd_ready), 0);
    clear_mon();
    wait_fs(5, "s2_wait");
    for (int i = 0; i < 4; i++) begin
      check("s2_pos", qget(fs_pos, i), exp_pos[i]);
      check("s2_pulse", qget(pulses, i), exp_pw[i]);
    end
    check("s2_model_pos", m_pos, 140);

    // Scenario 3: 10 then 200 back-to-back; 10 is overtaken.
    repeat (400) tick();
    cv = 1'b1; cp = 8'd10;
    tick();
    cp = 8'd200;
    b = 0;
    rdy_seen = 1'b0;
    while ((frame_start !== 1'b1) && (b < FRAME + 10)) begin
      if (cmd_ready === 1'b1) rdy_seen = 1'b1;
      tick();
      b++;
    end
    check("s3_ready_blocked", int'(rdy_seen), 0);
    check("s3_fs_seen", int'(frame_start), 1);
    check("s3_ready_at_fs", int'(cmd_ready), 1);
    check("s3_pos_toward_10", int'(position), 136);
    tick();
    cv = 1'b0;
    check("s3_200_accepted", int'(cmd_ready), 0);
    clear_mon();
    wait_fs(2, "s3_wait");
    check("s3_pos_a", qget(fs_pos, 0), 140);
    check("s3_pos_b", qget(fs_pos, 1), 144);

    // Scenario 4: drop enable at counter 50 of a centred frame.
    reset = 1'b1; en = 1'b0;
    repeat (2) tick();
    reset = 1'b0; en = 1'b1;
    clear_mon();
    wait_fs(1, "s4_wait");
    repeat (50) tick();
    en = 1'b0;
    fs_before = fs_cnt;
    repeat (1200) tick();
    check("s4_pulse_count", pulses.size(), 1);
    check("s4_pulse", qget(pulses, 0), 356);
    check("s4_no_fs", fs_cnt - fs_before, 0);
    check("s4_idle_pwm", int'(pwm), 0);

    // Scenario 5: command 0 handshaken in the frame-start cycle.
    en = 1'b1;
    wait_fs(1, "s5_wait");
    check("s5_fs_pos", int'(position), 128);
    check("s5_fs_ready", int'(cmd_ready), 1);
    cv = 1'b1; cp = 8'd0;
    tick();
    cv = 1'b0;
    check("s5_pos_hold", int'(position), 128);
    check("s5_pending", int'(cmd_ready), 0);
    wait_fs(1, "s5_wait2");
    check("s5_pos_dec", int'(position), 124);

    // Scenario 6: reset during HIGH with a pending command.
    cv = 1'b1; cp = 8'd77;
    tick();
    cv = 1'b0;
    repeat (20) tick();
    check("s6_pending_full", int'(cmd_ready), 0);
    check("s6_pwm_high", int'(pwm), 1);
    reset = 1'b1;
    tick();
    check("s6_pwm", int'(pwm), 0);
    check("s6_ready", int'(cmd_ready), 1);
    check("s6_pos", int'(position), 128);
    check("s6_fs", int'(frame_start), 0);
    reset = 1'b0;

    // Random traffic against the model.
    en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      cv = ($urandom_range(0, 3) == 0);
      cp = 8'($urandom);
      if ($urandom_range(0, 999) == 0) en = ~en;
      reset = ($urandom_range(0, 4999) == 0);
      tick();
    end
    reset = 1'b0;
    cv    = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- FRAME_CYC, 500000: PWM frame length in clk cycles (20 ms at 25 MHz).
- MIN_CYC, 25000: pulse width in clk cycles at position 0 (1.0 ms).
- STEP_CYC, 98: additional pulse cycles per position LSB.
- SLEW, 4: maximum position change per frame, in LSBs (1..255).
- CENTER, 128: position loaded at reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- i_Enable, input, 1: servo drive enable.
- i_Cmd_Valid, input, 1: position command valid.
- i_Cmd_Pos, input, 8: commanded position, unsigned 0..255.
- o_Cmd_Ready, output, 1: driver can accept a command.
- o_Pwm, output, 1: servo pulse output.
- o_Position, output, 8: position currently being driven.
- o_Frame_Start, output, 1: one-cycle strobe on the first cycle of each frame.
REQ-003 The block SHALL run on one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 A command SHALL be accepted on a rising clk edge when i_Cmd_Valid and o_Cmd_Ready are both 1.
REQ-005 Accepted commands SHALL be stored in a one-deep pending register.
- o_Cmd_Ready = 0 while the pending register is full.
- o_Cmd_Ready = 1 while it is empty.
REQ-006 The state machine SHALL have three states: IDLE, HIGH, LOW.
- IDLE -> HIGH when i_Enable = 1.
- HIGH -> LOW when the frame counter reaches the pulse width.
- LOW -> HIGH at frame end (counter = FRAME_CYC-1) when i_Enable = 1.
- LOW -> IDLE at frame end when i_Enable = 0.
REQ-007 Every entry into HIGH SHALL start a frame.
- The frame counter is cleared to 0.
- o_Frame_Start is 1 for exactly that cycle.
- Frame update order: (a) if the pending register is full, its value moves to target and pending becomes empty; (b) position steps toward target.
REQ-008 Position stepping SHALL work as follows.
- If |target - position| <= SLEW, position = target.
- Otherwise position moves SLEW toward target.
- Compute in 9-bit signed arithmetic; results never leave 0..255.
REQ-009 During a frame, pulse width = MIN_CYC + position*STEP_CYC, using the position computed at that frame's start.
REQ-010 o_Pwm SHALL be 1 in HIGH for frame counter values 0 .. width-1, and 0 otherwise.
REQ-011 Position and width SHALL NOT change mid-frame; a command accepted mid-frame takes effect at the next frame start.
REQ-012 If a command handshake occurs in the same cycle as a frame start while pending is empty, the new command SHALL go into pending and SHALL NOT take effect this frame.
REQ-013 Deasserting i_Enable mid-frame SHALL let the current frame complete with a full-length pulse, with no runt pulse; o_Pwm then stays 0 in IDLE.
REQ-014 Commands SHALL still be accepted in IDLE; they take effect at the first frame after re-enable.
REQ-015 o_Position SHALL always equal the internal position register.

Reset
REQ-016 While reset = 1, on each clk edge the block SHALL load these values:
- state IDLE; frame counter 0.
- o_Pwm 0; o_Frame_Start 0.
- pending empty, so o_Cmd_Ready 1.
- target = CENTER; position = CENTER.
REQ-017 Reset asserted mid-pulse SHALL force o_Pwm to 0 on the next edge, and any pending command SHALL be discarded.

Structure
REQ-018 Shared package servo_pkg SHALL hold:
- the state encoding: IDLE 2'b00, HIGH 2'b01, LOW 2'b10;
- the 8-bit position type;
- the default CENTER and SLEW constants.
REQ-019 The slew step SHALL be a separate sub-module, servo_slew_step: combinational, taking position, target and SLEW and returning the next position.
REQ-020 The frame counter SHALL be $clog2(FRAME_CYC) bits wide.
REQ-021 An elaboration check SHALL fail if MIN_CYC + 255*STEP_CYC >= FRAME_CYC.

Verification
REQ-022 The bench SHALL use FRAME_CYC=1000, MIN_CYC=100, STEP_CYC=2, SLEW=4, CENTER=128, and SHALL cover:
- Scenario 1: reset, i_Enable=1, no command -> every pulse is 356 cycles, period 1000 cycles, o_Position=128.
- Scenario 2: command 140 accepted mid-frame -> next frames show positions 132, 136, 140, 140 and pulses 364, 372, 380, 380.
- Scenario 3: commands 10 then 200 offered back-to-back -> 10 accepted; o_Cmd_Ready=0 until the next frame start; 200 accepted one cycle after that; 10 never reaches target.
- Scenario 4: i_Enable dropped at counter 50 of a frame with position 128 -> full 356-cycle pulse, then IDLE with o_Pwm=0 and no further o_Frame_Start.
- Scenario 5: command 0 with handshake in the o_Frame_Start cycle -> that frame's position unchanged; decrement starts the following frame.
- Scenario 6: reset asserted during HIGH with pending full -> next edge o_Pwm=0, o_Cmd_Ready=1, o_Position=128.
